stream_bram_fifo: RTL

STREAM_BRAM_FIFO -- requirements
Module: stream_bram_fifo

---
 rtl/stream_fifo_pkg.sv | 24 ++
 rtl/dp_bram.sv | 34 +++
 rtl/stream_bram_fifo.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared defaults and elaboration helpers for the stream FIFO family.
package stream_fifo_pkg;

    localparam int unsigned FIFO_WIDTH_DEF     = 72;
    localparam int unsigned FIFO_DEPTH_DEF     = 512;
    localparam int unsigned FIFO_LOG_DEPTH_DEF = 9;

    // Ceiling log2, exact for powers of two.
    function automatic int unsigned log2_f(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic bit is_pow2_f(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/dp_bram.sv
// Simple dual-port block RAM: port 1 writes, port 2 reads with a one-cycle registered output.
module dp_bram #(
    parameter int unsigned WIDTH  = 72,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [WIDTH-1:0]  p1_wdata_i,
    input  logic              p2_re_i,
    input  logic [ADDR_W-1:0] p2_addr_i,
    output logic [WIDTH-1:0]  p2_rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (p1_we_i) begin
            mem_q[p1_addr_i] <= p1_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (p2_re_i) begin
            rdata_q <= mem_q[p2_addr_i];
        end
    end

    assign p2_rdata_o = rdata_q;

endmodule

// File: rtl/stream_bram_fifo.sv
// Valid/ready stream FIFO: dual-port BRAM storage feeding a two-entry first-word-fall-through
// prefetch (output register plus skid register), with occupancy and threshold flags.
module stream_bram_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = FIFO_WIDTH_DEF,
    parameter int unsigned DEPTH     = FIFO_DEPTH_DEF,
    parameter int unsigned LOG_DEPTH = FIFO_LOG_DEPTH_DEF,
    parameter int unsigned AF_LEVEL  = DEPTH - 4,
    parameter int unsigned AE_LEVEL  = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [WIDTH-1:0]   ss_data,
    input  logic               ss_valid,
    output logic               ss_ready,
    output logic [WIDTH-1:0]   ms_data,
    output logic               ms_valid,
    input  logic               ms_ready,
    input  logic               flush,
    output logic [LOG_DEPTH:0] count,
    output logic               almost_full,
    output logic               almost_empty
);

    localparam int unsigned PW = LOG_DEPTH + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

    if (LOG_DEPTH != log2_f(DEPTH)) begin : g_bad_log_depth
        $fatal(1, "stream_bram_fifo: LOG_DEPTH does not equal log2(DEPTH)");
    end
    if (!is_pow2_f(DEPTH) || (DEPTH < 4) || (DEPTH > 65536)) begin : g_bad_depth
        $fatal(1, "stream_bram_fifo: DEPTH must be a power of two in 4..65536");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             space_q, space_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             rv_q, rv_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_v_q, out_v_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             skid_v_q, skid_v_d;

    logic             wr_fire_c;
    logic             rd_fire_c;
    logic             rd_issue_c;
    logic [1:0]       occ_c;
    logic [WIDTH-1:0] ram_rdata;

    // Handshakes and RAM read issue: only prefetch when the word can land without overflowing.
    always_comb begin
        wr_fire_c  = ss_valid && ss_ready;
        rd_fire_c  = out_v_q && ms_ready;
        occ_c      = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, rv_q} - {1'b0, rd_fire_c};
        rd_issue_c = (wr_ptr_q != rd_ptr_q) && (occ_c <= 2'd1) && !flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr_fire_c);
        rd_ptr_d = rd_ptr_q + PW'(rd_issue_c);
        rv_d     = rd_issue_c;
        out_d    = out_q;
        out_v_d  = out_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        count_d  = count_q;

        // Head refills from skid first, then from the RAM word arriving this cycle.
        if (!out_v_q || rd_fire_c) begin
            if (skid_v_q) begin
                out_d    = skid_q;
                out_v_d  = 1'b1;
                skid_d   = ram_rdata;
                skid_v_d = rv_q;
            end else begin
                out_d   = ram_rdata;
                out_v_d = rv_q;
            end
        end else if (rv_q) begin
            skid_d   = ram_rdata;
            skid_v_d = 1'b1;
        end

        case ({wr_fire_c, rd_fire_c})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            rv_d     = 1'b0;
            out_v_d  = 1'b0;
            skid_v_d = 1'b0;
            count_d  = '0;
        end

        space_d = (count_d < DEPTH_C);
        af_d    = (32'(count_d) >= AF_LEVEL);
        ae_d    = (32'(count_d) <= AE_LEVEL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            space_q  <= 1'b0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            rv_q     <= 1'b0;
            out_q    <= '0;
            out_v_q  <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            space_q  <= space_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            rv_q     <= rv_d;
            out_q    <= out_d;
            out_v_q  <= out_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end

    dp_bram #(
        .WIDTH  (WIDTH),
        .ADDR_W (LOG_DEPTH)
    ) u_ram (
        .clk        (clk),
        .p1_we_i    (wr_fire_c),
        .p1_addr_i  (wr_ptr_q[LOG_DEPTH-1:0]),
        .p1_wdata_i (ss_data),
        .p2_re_i    (rd_issue_c),
        .p2_addr_i  (rd_ptr_q[LOG_DEPTH-1:0]),
        .p2_rdata_o (ram_rdata)
    );

    assign ss_ready     = space_q && !flush;
    assign ms_data      = out_q;
    assign ms_valid     = out_v_q;
    assign count        = count_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

endmodule
